// File: rtl/player_pos_ctl.sv
// Player-1 mallet position: clamps mouse to own half, rate-limits per frame, returns home on goal.
// Latency: registers update on the frame_tick/goal_event cycle; no backpressure, every tick is consumed.
module player_pos_ctl #(
    parameter logic [11:0] X_MIN       = 12'd63,
    parameter logic [11:0] X_MAX       = 12'd467,
    parameter logic [11:0] Y_MIN       = 12'd63,
    parameter logic [11:0] Y_MAX       = 12'd706,
    parameter logic [11:0] HOME_X      = 12'd200,
    parameter logic [11:0] HOME_Y      = 12'd362,
    parameter int          MAX_STEP    = 8,
    parameter int          HOLD_FRAMES = 60
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        frame_tick,
    input  logic        goal_event,
    output logic [11:0] xpos_player,
    output logic [11:0] ypos_player,
    output logic [7:0]  vel_x,
    output logic [7:0]  vel_y,
    output logic        locked
);

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        RETURN = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic signed [12:0] STEP_P    = 13'(MAX_STEP);
    localparam logic signed [12:0] STEP_N    = -STEP_P;
    localparam logic [7:0]         HOLD_LOAD = 8'(HOLD_FRAMES - 1);

    state_t      state;
    logic [7:0]  hold_cnt;

    logic              home_tgt;
    logic [11:0]       tx;
    logic [11:0]       ty;
    logic signed [12:0] sx;
    logic signed [12:0] sy;
    logic [11:0]       nx;
    logic [11:0]       ny;
    logic              at_home;

    function automatic logic [11:0] clamp12(input logic [11:0] v,
                                            input logic [11:0] lo,
                                            input logic [11:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic logic signed [12:0] sat_step(input logic [11:0] t,
                                                    input logic [11:0] p);
        logic signed [12:0] d;
        d = $signed({1'b0, t}) - $signed({1'b0, p});
        if (d > STEP_P)
            return STEP_P;
        else if (d < STEP_N)
            return STEP_N;
        else
            return d;
    endfunction

    // A goal on the same cycle as a tick already steers that tick toward home.
    assign home_tgt = (state != TRACK) || goal_event;
    assign tx       = home_tgt ? HOME_X : clamp12(mouse_xpos, X_MIN, X_MAX);
    assign ty       = home_tgt ? HOME_Y : clamp12(mouse_ypos, Y_MIN, Y_MAX);
    assign sx       = sat_step(tx, xpos_player);
    assign sy       = sat_step(ty, ypos_player);
    assign nx       = 12'($unsigned({1'b0, xpos_player}) + $unsigned(sx));
    assign ny       = 12'($unsigned({1'b0, ypos_player}) + $unsigned(sy));
    assign at_home  = (nx == HOME_X) && (ny == HOME_Y);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            xpos_player <= HOME_X;
            ypos_player <= HOME_Y;
            vel_x       <= 8'd0;
            vel_y       <= 8'd0;
            locked      <= 1'b0;
            state       <= TRACK;
            hold_cnt    <= 8'd0;
        end else begin
            if (frame_tick) begin
                xpos_player <= nx;
                ypos_player <= ny;
                vel_x       <= sx[7:0];
                vel_y       <= sy[7:0];
                case (state)
                    RETURN: begin
                        if (at_home) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt != 8'd0) begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end else begin
                            state  <= TRACK;
                            locked <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            // Placed last so a goal overrides any tick-driven transition; ignored while already returning.
            if (goal_event && (state != RETURN)) begin
                state  <= RETURN;
                locked <= 1'b1;
            end
        end
    end

endmodule
